mtx_transpose_ctrl: RTL
=======================

// Module: mtx_transpose_ctrl
// PURPOSE
//  Memory-mapped peripheral on the openMSP430 peripheral bus with an on-chip 4x4 matrix buffer.
//  The CPU loads the matrix row-major through an auto-incrementing DATA port, then writes START.
//  An in-place transpose sequencer swaps the upper-triangle entries with the lower-triangle
//  entries, one swap per cycle. On completion it raises DONE and an optional interrupt.
//  Sits beside the existing mmreg-style peripherals, decoded at byte addresses 0x120-0x127.
// PARAMETERS
//  BASE_ADDR  14'h90  word address of CTRL (byte 0x120); DIM/IDX/DATA at +1/+2/+3
// PORTS
//  mclk      in   1   system clock, single clock domain
//  puc_rst   in   1   power-up clear; asynchronous, active-high
//  per_addr  in   14  peripheral word address
//  per_din   in   16  write data
//  per_en    in   1   active bus cycle enable
//  per_we    in   2   byte write enables; 2'b00 = read
//  per_dout  out  16  read data; 16'h0 when not selected or when the cycle is not a read
//  irq       out  1   level interrupt = DONE & IE
// BEHAVIOUR
//  Reset: all registers async-cleared, including the 16 buffer words. per_dout=0, irq=0, state=IDLE.
//  Bus: acts only when per_en=1 and per_addr is in BASE_ADDR..+3.
//   - Writes take effect only with per_we==2'b11. Byte writes are ignored.
//   - Reads occur with per_we==2'b00 and are combinational in the same cycle.
//  Register map (word offsets):
//   +0 CTRL   W: b0 START, b1 CLR_DONE, b2 IE (IE stored).  R: {13'b0, IE, DONE, BUSY}.
//   +1 DIM    R/W b[1:0] = N-1 (N=1..4); other bits read 0.
//   +2 IDX    R/W b[3:0] buffer index; element (r,c) is at index 4*r+c regardless of N.
//   +3 DATA   R/W buffer[IDX]. Each full-word write or read of DATA post-increments IDX mod 16.
//  FSM states: IDLE, SWAP, DONE_ST (2-bit encoding, defined in the package).
//   IDLE->SWAP on a CTRL write with START=1. The write also clears DONE. i=0, j=1 are loaded.
//   SWAP: if i<N-1, then in one cycle buf[4i+j] <-> buf[4j+i]. Advance j. When j==N-1,
//         set i=i+1, j=i+2. Leave SWAP after the final swap (i=N-2, j=N-1).
//   For N=1, SWAP lasts exactly 1 cycle with no write.
//   SWAP->DONE_ST sets DONE (sticky). DONE_ST->IDLE on the next cycle.
//  Latency: START write in cycle k. BUSY=1 in cycles k+1..k+S, where S=max(1,N(N-1)/2).
//   DONE reads 1 from cycle k+S+1. For N=4, S=6.
//  BUSY = (state==SWAP). While BUSY:
//   - DIM, IDX and DATA writes are ignored. DATA reads return 0 and do not increment IDX.
//   - START is ignored. CLR_DONE and IE writes are still honoured.
//  CLR_DONE=1 clears DONE. If START=1 and CLR_DONE=1 in the same write, START wins (DONE=0, run).
//  DONE_ST and IDLE both accept START.
//  Entries outside the NxN sub-matrix are never modified.
//  An async reset mid-SWAP aborts: IDLE, buffer zeroed, DONE=0. No partial-state recovery.
//  IDX wraps 15->0 silently.
// STRUCTURE
//  Package mtx_pkg:
//   - register word offsets CTRL/DIM/IDX/DATA
//   - CTRL bit positions
//   - FSM state localparams
//   - MAX_N=4
//  Sub-module mtx_buf: 16x16 register array with async clear, one bus read/write port
//   (index, wdata, we), and one swap port (idx_a, idx_b, swap_en).
//   Bus and swap are never active together; the controller guarantees this via BUSY.
//  Top level holds the address decode, CTRL/DIM/IDX registers, FSM and i/j counters, and the read mux.
// TESTING
//  1. Reset: assert puc_rst mid-idle -> all 4 registers read 0, irq=0, every DATA read returns 0.
//  2. N=4: write DIM=3, IDX=0, then DATA=0..15; START with IE=1.
//     -> BUSY for exactly 6 cycles, then DONE=1, irq=1.
//     IDX=0 then 16 DATA reads -> 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
//  3. N=2: load 0..15, then START.
//     -> 1 busy cycle; only indices 1 and 4 swap; all other entries unchanged.
//     N=1 -> 1 busy cycle, buffer unchanged, DONE=1.
//  4. During BUSY: write DATA=16'hDEAD, write IDX=5, second START, read DATA.
//     -> all ignored, read returns 0, result identical to scenario 2.
//  5. Byte/decoding: DATA write with per_we=2'b01 -> no write, IDX unchanged.
//     Access at BASE_ADDR+4 -> per_dout=0, no state change.
//     IDX=15 then DATA write -> IDX reads 0.
//  6. Reset at cycle 3 of SWAP -> IDLE, DONE=0, buffer zeroed.
//     CTRL write with START|CLR_DONE after DONE -> DONE=0, BUSY=1 next cycle.

Source files
------------

// File: rtl/mtx_pkg.sv
// rtl/mtx_pkg.sv - shared constants, state encoding and index helper for the matrix transpose peripheral
package mtx_pkg;

    localparam int MAX_N = 4;

    // Register word offsets relative to BASE_ADDR
    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_DIM  = 2'd1;
    localparam logic [1:0] OFF_IDX  = 2'd2;
    localparam logic [1:0] OFF_DATA = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_IE       = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SWAP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Element (r,c) lives at 4*r+c, independent of the active dimension
    function automatic logic [3:0] elem_idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/mtx_buf.sv
// rtl/mtx_buf.sv - 16-word matrix buffer with one bus port and one swap port
module mtx_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bus_idx,
    input  logic [15:0] bus_wdata,
    input  logic        bus_we,
    output logic [15:0] bus_rdata,
    input  logic [3:0]  swap_idx_a,
    input  logic [3:0]  swap_idx_b,
    input  logic        swap_en
);

    logic [15:0] mem_q [16];
    logic [15:0] mem_d [16];

    // Next buffer contents: a swap exchanges two words, otherwise a bus write updates one
    always_comb begin
        mem_d = mem_q;
        if (swap_en) begin
            mem_d[swap_idx_a] = mem_q[swap_idx_b];
            mem_d[swap_idx_b] = mem_q[swap_idx_a];
        end else if (bus_we) begin
            mem_d[bus_idx] = bus_wdata;
        end
    end

    // Buffer storage, fully cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: 16'h0000};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus_rdata = mem_q[bus_idx];

endmodule

// File: rtl/mtx_transpose_ctrl.sv
// rtl/mtx_transpose_ctrl.sv - peripheral-bus 4x4 in-place matrix transpose controller
module mtx_transpose_ctrl #(
    parameter logic [13:0] BASE_ADDR = 14'h90
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq
);
    import mtx_pkg::*;

    state_t      state_q, state_d;
    logic [1:0]  i_q, i_d;
    logic [1:0]  j_q, j_d;
    logic [1:0]  dim_q, dim_d;
    logic [3:0]  idx_q, idx_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;

    logic [13:0] addr_off;
    logic        sel, wr_en, rd_en, busy;
    logic        wr_ctrl, wr_dim, wr_idx, data_acc, start;
    logic        swap_en;
    logic [15:0] buf_rdata;

    assign addr_off = per_addr - BASE_ADDR;
    assign sel      = per_en && (addr_off < 14'd4);
    assign wr_en    = sel && (per_we == 2'b11);
    assign rd_en    = sel && (per_we == 2'b00);
    assign busy     = (state_q == ST_SWAP);

    assign wr_ctrl  = wr_en && (addr_off[1:0] == OFF_CTRL);
    assign wr_dim   = wr_en && (addr_off[1:0] == OFF_DIM) && !busy;
    assign wr_idx   = wr_en && (addr_off[1:0] == OFF_IDX) && !busy;
    // Any full-word DATA access outside SWAP touches the buffer and bumps IDX
    assign data_acc = (wr_en || rd_en) && (addr_off[1:0] == OFF_DATA) && !busy;
    assign start    = wr_ctrl && per_din[CTRL_START] && !busy;

    mtx_buf u_buf (
        .clk        (mclk),
        .rst        (puc_rst),
        .bus_idx    (idx_q),
        .bus_wdata  (per_din),
        .bus_we     (data_acc && wr_en),
        .bus_rdata  (buf_rdata),
        .swap_idx_a (elem_idx(i_q, j_q)),
        .swap_idx_b (elem_idx(j_q, i_q)),
        .swap_en    (swap_en)
    );

    // Sequencer next state: walk the upper triangle one (i,j) pair per cycle
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        swap_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SWAP;
                    i_d     = 2'd0;
                    j_d     = 2'd1;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWAP: begin
                if (dim_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    swap_en = 1'b1;
                    if (j_q == dim_q) begin
                        if (i_q == dim_q - 2'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + 2'd1;
                            j_d = i_q + 2'd2;
                        end
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file next state; completion sets DONE after any clear in the same cycle
    always_comb begin
        dim_d  = dim_q;
        idx_d  = idx_q;
        ie_d   = ie_q;
        done_d = done_q;
        if (wr_dim) dim_d = per_din[1:0];
        if (wr_idx) begin
            idx_d = per_din[3:0];
        end else if (data_acc) begin
            idx_d = idx_q + 4'd1;
        end
        if (wr_ctrl) begin
            ie_d = per_din[CTRL_IE];
            if (per_din[CTRL_CLR_DONE]) done_d = 1'b0;
        end
        if (start) done_d = 1'b0;
        if (busy && (state_d == ST_DONE)) done_d = 1'b1;
    end

    // All control state, asynchronously cleared by power-up clear
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= ST_IDLE;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            dim_q   <= 2'd0;
            idx_q   <= 4'd0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            dim_q   <= dim_d;
            idx_q   <= idx_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
        end
    end

    // Combinational read mux; DATA hides the buffer while the sequencer owns it
    always_comb begin
        per_dout = 16'h0000;
        if (rd_en) begin
            case (addr_off[1:0])
                OFF_CTRL: per_dout = {13'd0, ie_q, done_q, busy};
                OFF_DIM:  per_dout = {14'd0, dim_q};
                OFF_IDX:  per_dout = {12'd0, idx_q};
                default:  per_dout = busy ? 16'h0000 : buf_rdata;
            endcase
        end
    end

    assign irq = done_q & ie_q;

endmodule
